// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage plus MEM/WB register.
// Issues data-memory loads/stores over a req/ack handshake, formats load data,
// builds store byte enables and stalls upstream while an access is outstanding.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses
// into a one-cycle bubble flagged on the extra misalign output.
module mem_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           rs2_data,
  input  logic [4:0]            rd,
  input  logic                  reg_write,
  input  logic                  mem_reg,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic [31:0]           memwb_mem_data,
  output logic [31:0]           memwb_alu_result,
  output logic [4:0]            memwb_rd,
  output logic                  memwb_reg_write,
  output logic                  memwb_mem_reg
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  // Instruction fields captured when an access is issued; stable during WAIT.
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        regw_q, regw_d;
  logic        memreg_q, memreg_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  // MEM/WB register.
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regw_q, wb_regw_d;
  logic        wb_memreg_q, wb_memreg_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  // Select byte/half lane and sign- or zero-extend; other encodings are words.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction
`endif

  // Next-state, stall and MEM/WB contents; a bubble is the all-zero default.
  always_comb begin
    state_d     = state_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    regw_d      = regw_q;
    memreg_d    = memreg_q;
    f3_d        = f3_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    wb_data_d   = 32'd0;
    wb_alu_d    = 32'd0;
    wb_rd_d     = 5'd0;
    wb_regw_d   = 1'b0;
    wb_memreg_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d       = 1'b0;
`endif
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (!(mem_reg || mem_write)) begin
            wb_alu_d    = alu_result;
            wb_rd_d     = rd;
            wb_regw_d   = reg_write;
            wb_memreg_d = mem_reg;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (is_misaligned(funct3[1:0], alu_result[1:0])) begin
            mis_d = 1'b1;
          end
`endif
          else begin
            stall    = 1'b1;
            state_d  = S_WAIT;
            alu_d    = alu_result;
            rd_d     = rd;
            regw_d   = reg_write;
            memreg_d = mem_reg;
            f3_d     = funct3;
            we_d     = mem_write;
            be_d     = mem_write ? store_be(funct3[1:0], alu_result[1:0]) : 4'b1111;
            wdata_d  = store_wdata(funct3[1:0], rs2_data);
          end
        end
      end
      default: begin
        stall = !dmem_ack;
        if (dmem_ack) begin
          state_d     = S_IDLE;
          wb_data_d   = memreg_q ? fmt_load(f3_q, alu_q[1:0], dmem_rdata) : 32'd0;
          wb_alu_d    = alu_q;
          wb_rd_d     = rd_q;
          wb_regw_d   = regw_q;
          wb_memreg_d = memreg_q;
        end
      end
    endcase
    if (rst) stall = 1'b0;
  end

  // State, request latches and MEM/WB register; reset aborts any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_q       <= 32'd0;
      rd_q        <= 5'd0;
      regw_q      <= 1'b0;
      memreg_q    <= 1'b0;
      f3_q        <= 3'd0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      wb_data_q   <= 32'd0;
      wb_alu_q    <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_regw_q   <= 1'b0;
      wb_memreg_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      regw_q      <= regw_d;
      memreg_q    <= memreg_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      wb_data_q   <= wb_data_d;
      wb_alu_q    <= wb_alu_d;
      wb_rd_q     <= wb_rd_d;
      wb_regw_q   <= wb_regw_d;
      wb_memreg_q <= wb_memreg_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign dmem_req         = (state_q == S_WAIT);
  assign dmem_we          = we_q;
  assign dmem_addr        = {alu_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata       = wdata_q;
  assign dmem_be          = be_q;
  assign memwb_mem_data   = wb_data_q;
  assign memwb_alu_result = wb_alu_q;
  assign memwb_rd         = wb_rd_q;
  assign memwb_reg_write  = wb_regw_q;
  assign memwb_mem_reg    = wb_memreg_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign         = mis_q;
`endif

endmodule
